operand_fetch: RTL and testbench
================================

# operand_fetch

Operand-fetch stage sitting directly upstream of the ALU. Holds the 32×32-bit integer register file and resolves source operands with bypassing from the execute and writeback stages. Presents one registered, ALU-ready operation per cycle behind a valid/ready handshake. Its `ALU_OP_o`, `ALU_RS1_o` and `ALU_RS2_o` outputs connect directly to the ALU's `ALU_OP_i`, `ALU_RS1_i` and `ALU_RS2_i`.

## Interface
- No parameters: 32 registers, 32-bit data, 4-bit ALU opcode, all fixed.
- `clk`  in  1  Single clock; all state updates on the rising edge.
- `rst`  in  1  Reset, synchronous and active-high.
- `in_valid_i`  in  1  Decoded instruction present.
- `in_ready_o`  out  1  Stage can accept this cycle.
- `in_op_i`  in  4  ALU opcode, passed through unchanged.
- `in_rs1_addr_i`, `in_rs2_addr_i`  in  5 each  Source register indices.
- `in_rd_addr_i`  in  5  Destination index, passed through.
- `in_imm_i`  in  32  Immediate value, already sign-extended.
- `in_use_imm_i`  in  1  When 1, operand 2 is `in_imm_i` instead of rs2.
- `ex_fwd_en_i`, `ex_fwd_addr_i[4:0]`, `ex_fwd_data_i[31:0]`  in  Bypass from the ALU result of the instruction currently in execute.
- `wb_en_i`, `wb_addr_i[4:0]`, `wb_data_i[31:0]`  in  Register-file write port (writeback).
- `out_valid_o`  out  1  Output register holds a valid operation.
- `out_ready_i`  in  1  ALU/execute stage consumes the operation this cycle.
- `ALU_OP_o`  out  4  Registered opcode.
- `ALU_RS1_o`, `ALU_RS2_o`  out  32 each  Registered operands.
- `out_rd_addr_o`  out  5  Registered destination index.

## Operation
- **Register file.** 32 entries.
  - x0 always reads 0. Writes to x0 are discarded.
  - On each edge with `wb_en_i`=1, `wb_addr_i`≠0 and `rst`=0, the entry at `wb_addr_i` is written with `wb_data_i`.
- **Operand resolution.** Combinational, applied independently to rs1 and rs2. Priority, first match wins:
  1. Address = 0 → 0.
  2. `ex_fwd_en_i` and `ex_fwd_addr_i` = addr → `ex_fwd_data_i`.
  3. `wb_en_i` and `wb_addr_i` = addr → `wb_data_i` (same-cycle write bypass).
  4. Otherwise → register file contents.
- **Operand 2 select.** Operand 2 = `in_imm_i` if `in_use_imm_i`=1, else the resolved rs2.
- **Accept condition.** A transfer is accepted when `in_valid_i` && `in_ready_o`.
- **Ready.** `in_ready_o` = !`rst` && (!`out_valid_o` || `out_ready_i`). This is a single-entry pipeline register with full throughput.
- **Two-state machine.**
  - EMPTY (`out_valid_o`=0) → FULL on accept.
  - FULL → FULL on simultaneous consume and accept; the register is reloaded with the new operation.
  - FULL → EMPTY on consume without accept.
  - FULL holds while `out_ready_i`=0.
- **Stall behaviour.** While FULL and stalled, all outputs hold bit-exact. Operands are captured at accept time and are not refreshed by later writebacks; hazard control belongs upstream.
- **Data passes untouched.** No arithmetic is performed. Opcode and rd pass through unchanged; undefined opcodes are passed as-is.

## Timing
- **Reset.** While `rst`=1 at an edge:
  - All 32 registers clear to 0.
  - `out_valid_o`=0.
  - `ALU_OP_o`=4'b0000, `ALU_RS1_o`=0, `ALU_RS2_o`=0, `out_rd_addr_o`=0.
  - `in_ready_o`=0 during reset.
  - A `wb_en_i` write in the same cycle is ignored.
- **Reset mid-operation.** A pending FULL operation is dropped. First accept is possible in the cycle after `rst` falls.
- **Latency.** Accept in cycle N → `out_valid_o`=1 with the operands from cycle N in cycle N+1.
- **Throughput.** One operation per cycle while `out_ready_i`=1.
- **Write/read same cycle.** A write in cycle N is visible to a read in cycle N via bypass, and via the register file from N+1.
- **Simultaneous write and forward.** When ex-forward and wb target the same register:
  - The operand takes the ex value.
  - The register file still receives the wb value.
- **Outputs registered.** No combinational path from `in_*` to `ALU_*_o`. The only combinational in-to-out path is `out_ready_i` → `in_ready_o`.

## Test plan
- **Reset.** Assert `rst` 2 cycles with `wb_en_i`=1, `wb_addr_i`=5, `wb_data_i`=0xDEAD → `out_valid_o`=0, all outputs 0, `in_ready_o`=0. Then read x5 → 0.
- **Write then read / x0.** Write x3=0x0000_0010 in cycle 1. Accept op=4'b0010 with rs1=3, rs2=0 in cycle 2 → cycle 3: `ALU_RS1_o`=0x10, `ALU_RS2_o`=0. Write x0=0xFFFF_FFFF, then read x0 → 0.
- **Bypass priority.** Set x7=1 in the register file. In one cycle drive wb x7=2 and ex x7=3, and accept rs1=7, rs2=7 → both operands 3. Next cycle x7 reads 2.
- **Immediate select.** rs2=4 (x4=9), `in_use_imm_i`=1, `in_imm_i`=0xFFFF_FFF8 → `ALU_RS2_o`=0xFFFF_FFF8.
- **Backpressure.** Accept A, hold `out_ready_i`=0 for 3 cycles while offering B and writing A's source register:
  - Outputs stay equal to A's operands.
  - `in_ready_o`=0.
  - When `out_ready_i`=1, B is accepted in the same cycle and appears the next cycle.
- **Reset mid-stream.** Assert `rst` during back-to-back transfers at full throughput → `out_valid_o`=0 next cycle, no stale operation reappears after release.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch: 32x32 register file with ex/wb bypass feeding one registered ALU operation.
// Latency: 1 cycle from accept to out_valid_o; one operation per cycle at full throughput.
// Backpressure: single-entry output register; in_ready_o drops only while full and out_ready_i is low, or in reset.
module operand_fetch (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [3:0]  in_op_i,
    input  logic [4:0]  in_rs1_addr_i,
    input  logic [4:0]  in_rs2_addr_i,
    input  logic [4:0]  in_rd_addr_i,
    input  logic [31:0] in_imm_i,
    input  logic        in_use_imm_i,
    input  logic        ex_fwd_en_i,
    input  logic [4:0]  ex_fwd_addr_i,
    input  logic [31:0] ex_fwd_data_i,
    input  logic        wb_en_i,
    input  logic [4:0]  wb_addr_i,
    input  logic [31:0] wb_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  ALU_OP_o,
    output logic [31:0] ALU_RS1_o,
    output logic [31:0] ALU_RS2_o,
    output logic [4:0]  out_rd_addr_o
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t      state;
    logic [31:0] regs [32];
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] op2_val;
    logic        accept;

    // Execute result outranks the writeback value so the youngest producer wins.
    function automatic logic [31:0] resolve(input logic [4:0] addr, input logic [31:0] rf_data);
        logic [31:0] val;
        if (addr == 5'd0)
            val = 32'd0;
        else if (ex_fwd_en_i && (ex_fwd_addr_i == addr))
            val = ex_fwd_data_i;
        else if (wb_en_i && (wb_addr_i == addr))
            val = wb_data_i;
        else
            val = rf_data;
        return val;
    endfunction

    always_comb begin
        rs1_val = resolve(in_rs1_addr_i, regs[in_rs1_addr_i]);
        rs2_val = resolve(in_rs2_addr_i, regs[in_rs2_addr_i]);
        op2_val = in_use_imm_i ? in_imm_i : rs2_val;
    end

    assign out_valid_o = (state == FULL);
    assign in_ready_o  = !rst && (!out_valid_o || out_ready_i);
    assign accept      = in_valid_i && in_ready_o;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= 32'd0;
        end else if (wb_en_i && (wb_addr_i != 5'd0)) begin
            regs[wb_addr_i] <= wb_data_i;
        end
    end

    // Operands are frozen at accept time; later writebacks do not refresh a stalled entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= EMPTY;
            ALU_OP_o      <= 4'd0;
            ALU_RS1_o     <= 32'd0;
            ALU_RS2_o     <= 32'd0;
            out_rd_addr_o <= 5'd0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept)
                        state <= FULL;
                end
                FULL: begin
                    if (!accept && out_ready_i)
                        state <= EMPTY;
                end
                default: state <= EMPTY;
            endcase
            if (accept) begin
                ALU_OP_o      <= in_op_i;
                ALU_RS1_o     <= rs1_val;
                ALU_RS2_o     <= op2_val;
                out_rd_addr_o <= in_rd_addr_i;
            end
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized and directed stimulus against a register-array reference model with a queue scoreboard.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [3:0]  in_op_i;
    logic [4:0]  in_rs1_addr_i, in_rs2_addr_i, in_rd_addr_i;
    logic [31:0] in_imm_i;
    logic        in_use_imm_i;
    logic        ex_fwd_en_i;
    logic [4:0]  ex_fwd_addr_i;
    logic [31:0] ex_fwd_data_i;
    logic        wb_en_i;
    logic [4:0]  wb_addr_i;
    logic [31:0] wb_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [3:0]  ALU_OP_o;
    logic [31:0] ALU_RS1_o, ALU_RS2_o;
    logic [4:0]  out_rd_addr_o;

    always #5 clk = ~clk;

    operand_fetch dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_op_i(in_op_i), .in_rs1_addr_i(in_rs1_addr_i), .in_rs2_addr_i(in_rs2_addr_i),
        .in_rd_addr_i(in_rd_addr_i), .in_imm_i(in_imm_i), .in_use_imm_i(in_use_imm_i),
        .ex_fwd_en_i(ex_fwd_en_i), .ex_fwd_addr_i(ex_fwd_addr_i), .ex_fwd_data_i(ex_fwd_data_i),
        .wb_en_i(wb_en_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .ALU_OP_o(ALU_OP_o), .ALU_RS1_o(ALU_RS1_o), .ALU_RS2_o(ALU_RS2_o),
        .out_rd_addr_o(out_rd_addr_o)
    );

    typedef struct {
        logic        rst, valid, use_imm, ex_en, wb_en, ordy;
        logic [3:0]  op;
        logic [4:0]  rs1, rs2, rd, ex_a, wb_a;
        logic [31:0] imm, ex_d, wb_d;
    } drive_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mregs [32];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        prev_rst = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic drive_t idle();
        drive_t d;
        d = '{rst: 1'b0, valid: 1'b0, use_imm: 1'b0, ex_en: 1'b0, wb_en: 1'b0, ordy: 1'b1,
              op: 4'd0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, ex_a: 5'd0, wb_a: 5'd0,
              imm: 32'd0, ex_d: 32'd0, wb_d: 32'd0};
        return d;
    endfunction

    function automatic drive_t op_d(input logic [3:0] op, input logic [4:0] rs1,
                                    input logic [4:0] rs2, input logic [4:0] rd);
        drive_t d;
        d = idle();
        d.valid = 1'b1; d.op = op; d.rs1 = rs1; d.rs2 = rs2; d.rd = rd;
        return d;
    endfunction

    function automatic drive_t wr_d(input logic [4:0] a, input logic [31:0] v);
        drive_t d;
        d = idle();
        d.wb_en = 1'b1; d.wb_a = a; d.wb_d = v;
        return d;
    endfunction

    task automatic put(input drive_t d);
        rst = d.rst; in_valid_i = d.valid; in_op_i = d.op;
        in_rs1_addr_i = d.rs1; in_rs2_addr_i = d.rs2; in_rd_addr_i = d.rd;
        in_imm_i = d.imm; in_use_imm_i = d.use_imm;
        ex_fwd_en_i = d.ex_en; ex_fwd_addr_i = d.ex_a; ex_fwd_data_i = d.ex_d;
        wb_en_i = d.wb_en; wb_addr_i = d.wb_a; wb_data_i = d.wb_d;
        out_ready_i = d.ordy;
    endtask

    task automatic apply(input drive_t d);
        @(posedge clk);
        #1;
        put(d);
    endtask

    // Reference operand: zero register, then execute result, then writeback, then stored value.
    function automatic logic [31:0] ref_operand(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (ex_fwd_en_i && ex_fwd_addr_i == a) return ex_fwd_data_i;
        if (wb_en_i && wb_addr_i == a) return wb_data_i;
        return mregs[a];
    endfunction

    // Model update, one tick after the monitor has looked at the current output.
    always @(negedge clk) begin
        #1;
        if (rst) begin
            for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
            sb.delete();
        end else begin
            if (in_valid_i && in_ready_o) begin
                exp_t e;
                e.op = in_op_i;
                e.a  = ref_operand(in_rs1_addr_i);
                e.b  = in_use_imm_i ? in_imm_i : ref_operand(in_rs2_addr_i);
                e.rd = in_rd_addr_i;
                sb.push_back(e);
            end
            if (wb_en_i && wb_addr_i != 5'd0) mregs[wb_addr_i] = wb_data_i;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("ready_in_reset", {31'd0, in_ready_o}, 32'd0);
        end else begin
            if (prev_rst) begin
                check("rst_valid", {31'd0, out_valid_o}, 32'd0);
                check("rst_op", {28'd0, ALU_OP_o}, 32'd0);
                check("rst_rs1", ALU_RS1_o, 32'd0);
                check("rst_rs2", ALU_RS2_o, 32'd0);
                check("rst_rd", {27'd0, out_rd_addr_o}, 32'd0);
            end
            check("out_valid", {31'd0, out_valid_o}, {31'd0, sb.size() != 0});
            check("in_ready", {31'd0, in_ready_o}, {31'd0, (sb.size() == 0) || out_ready_i});
            if (out_valid_o && sb.size() != 0) begin
                check("alu_op", {28'd0, ALU_OP_o}, {28'd0, sb[0].op});
                check("alu_rs1", ALU_RS1_o, sb[0].a);
                check("alu_rs2", ALU_RS2_o, sb[0].b);
                check("rd_addr", {27'd0, out_rd_addr_o}, {27'd0, sb[0].rd});
                if (out_ready_i) void'(sb.pop_front());
            end
        end
        prev_rst = rst;
    end

    initial begin
        drive_t d;
        d = idle(); d.rst = 1'b1; d.wb_en = 1'b1; d.wb_a = 5'd5; d.wb_d = 32'hDEAD;
        put(d);
        apply(d);
        apply(d);
        apply(op_d(4'd1, 5'd5, 5'd5, 5'd1));

        // write then read, x0 discard
        apply(wr_d(5'd3, 32'h10));
        apply(op_d(4'b0010, 5'd3, 5'd0, 5'd9));
        apply(wr_d(5'd0, 32'hFFFF_FFFF));
        apply(op_d(4'd3, 5'd0, 5'd0, 5'd2));

        // bypass priority: ex beats wb, regfile gets wb
        apply(wr_d(5'd7, 32'd1));
        d = op_d(4'd4, 5'd7, 5'd7, 5'd7);
        d.wb_en = 1'b1; d.wb_a = 5'd7; d.wb_d = 32'd2;
        d.ex_en = 1'b1; d.ex_a = 5'd7; d.ex_d = 32'd3;
        apply(d);
        apply(op_d(4'd5, 5'd7, 5'd7, 5'd8));

        // immediate select
        apply(wr_d(5'd4, 32'd9));
        d = op_d(4'd6, 5'd3, 5'd4, 5'd10);
        d.use_imm = 1'b1; d.imm = 32'hFFFF_FFF8;
        apply(d);

        // backpressure: A stalls 3 cycles while its source is rewritten
        apply(op_d(4'hA, 5'd3, 5'd4, 5'd11));
        for (int i = 0; i < 3; i++) begin
            d = op_d(4'hB, 5'd3, 5'd4, 5'd12);
            d.ordy = 1'b0; d.wb_en = 1'b1; d.wb_a = 5'd3; d.wb_d = 32'h55 + i;
            apply(d);
        end
        apply(op_d(4'hB, 5'd3, 5'd4, 5'd12));
        apply(idle());

        // reset mid-stream at full throughput
        for (int i = 0; i < 4; i++) apply(op_d(4'(i), 5'(i + 1), 5'(i + 2), 5'(i)));
        d = op_d(4'hF, 5'd3, 5'd4, 5'd13); d.rst = 1'b1;
        apply(d);
        for (int i = 0; i < 4; i++) apply(op_d(4'(i + 8), 5'(i), 5'(7 - i), 5'(20 + i)));

        for (int n = 0; n < 3000; n++) begin
            d = idle();
            d.rst     = ($urandom_range(0, 99) == 0);
            d.valid   = ($urandom_range(0, 3) != 0);
            d.ordy    = ($urandom_range(0, 9) < 7);
            d.op      = 4'($urandom);
            d.rs1     = 5'($urandom_range(0, 7));
            d.rs2     = 5'($urandom_range(0, 7));
            d.rd      = 5'($urandom);
            d.use_imm = ($urandom_range(0, 3) == 0);
            d.imm     = $urandom;
            d.ex_en   = ($urandom_range(0, 2) == 0);
            d.ex_a    = 5'($urandom_range(0, 7));
            d.ex_d    = $urandom;
            d.wb_en   = ($urandom_range(0, 1) == 0);
            d.wb_a    = 5'($urandom_range(0, 7));
            d.wb_d    = $urandom;
            apply(d);
        end

        for (int i = 0; i < 4; i++) apply(idle());
        @(posedge clk);
        #2;
        check("drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
